operand_fwd_unit: RTL

OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

---
 rtl/operand_fwd_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/operand_fwd_unit.sv
// EX-stage operand forwarding with load-use stall detection.
// Forwards from EX/MEM, MEM/WB or a one-shot hold register captured during the stall bubble.
module operand_fwd_unit #(
    parameter int XLEN   = 32,
    parameter int NUM_RS = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RS*5-1:0]      rs_addr,
    input  logic [NUM_RS-1:0]        rs_used,
    input  logic [NUM_RS*XLEN-1:0]   rs_data_in,
    input  logic [4:0]               ex_mem_addr,
    input  logic [XLEN-1:0]          ex_mem_data,
    input  logic                     ex_mem_w,
    input  logic                     ex_mem_is_load,
    input  logic [4:0]               mem_wb_addr,
    input  logic [XLEN-1:0]          mem_wb_data,
    input  logic                     mem_wb_w,
    input  logic                     freeze,
    output logic [NUM_RS*XLEN-1:0]   fwd_data,
    output logic [NUM_RS*2-1:0]      fwd_src,
    output logic                     stall_out,
    output logic [CNT_W-1:0]         lu_stall_cnt
);

    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    localparam logic [1:0] SRC_RF   = 2'd0;
    localparam logic [1:0] SRC_EXM  = 2'd1;
    localparam logic [1:0] SRC_WB   = 2'd2;
    localparam logic [1:0] SRC_HOLD = 2'd3;

    logic [0:0]              r_state;
    logic [NUM_RS-1:0]       r_hold_valid;
    logic [NUM_RS*XLEN-1:0]  r_hold_data;
    logic [CNT_W-1:0]        r_cnt;

    logic [NUM_RS-1:0]       w_exm;
    logic [NUM_RS-1:0]       w_wbm;
    logic                    w_haz;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_exm = '0;
        w_wbm = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_exm[i] = ex_mem_w && (ex_mem_addr == rs_addr[i*5 +: 5]) && (ex_mem_addr != 5'd0);
            w_wbm[i] = mem_wb_w && (mem_wb_addr == rs_addr[i*5 +: 5]) && (mem_wb_addr != 5'd0);
        end
    end

    always_comb begin
        fwd_data = rs_data_in;
        fwd_src  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_used[i]) begin
                if (w_exm[i]) begin
                    fwd_data[i*XLEN +: XLEN] = ex_mem_data;
                    fwd_src[i*2 +: 2]        = SRC_EXM;
                end else if (w_wbm[i]) begin
                    fwd_data[i*XLEN +: XLEN] = mem_wb_data;
                    fwd_src[i*2 +: 2]        = SRC_WB;
                end else if (r_hold_valid[i]) begin
                    fwd_data[i*XLEN +: XLEN] = r_hold_data[i*XLEN +: XLEN];
                    fwd_src[i*2 +: 2]        = SRC_HOLD;
                end else begin
                    fwd_src[i*2 +: 2]        = SRC_RF;
                end
            end
        end
    end

    // Stall is requested even while frozen; the FSM simply does not act on it until unfrozen.
    assign w_haz        = (r_state == ST_RUN) && ex_mem_is_load && |(rs_used & w_exm);
    assign stall_out    = w_haz;
    assign lu_stall_cnt = r_cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_state      <= ST_RUN;
            r_hold_valid <= '0;
            r_hold_data  <= '0;
            r_cnt        <= '0;
        end else if (!freeze) begin
            case (r_state)
                ST_RUN: begin
                    if (w_haz) begin
                        r_state <= ST_LOAD_WAIT;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        // The value retiring from MEM/WB during the bubble would otherwise be lost.
                        r_hold_valid <= rs_used & w_wbm & ~w_exm;
                        r_hold_data  <= {NUM_RS{mem_wb_data}};
                    end else begin
                        r_hold_valid <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_hold_valid <= '0;
                end
            endcase
        end
    end

endmodule
